// File: rtl/pickup_tx_serializer.sv
// Pickup LVDS link transmitter: trains the far end, then serializes one word per frame MSB-first.
// Optional build macro PICKUP_TX_STATS_EN adds frame/underrun statistics counters.
module pickup_tx_serializer #(
   parameter int unsigned          CHANNELS     = 2,
   parameter int unsigned          PER_BIT      = 6,
   parameter int unsigned          MAXBIT       = CHANNELS * PER_BIT,
   parameter int unsigned          TRAIN_FRAMES = 16,
   parameter logic [PER_BIT-1:0]   TRAIN_WORD   = PER_BIT'(6'b111000)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   input  logic [MAXBIT:1]     tx_data_i,
   input  logic                tx_valid_i,
   output logic                tx_ready_c_o,
   output logic [CHANNELS-1:0] channel_data_o,
   output logic                bitclk_o,
   output logic                frameclk_o,
   output logic                underrun_o,
   output logic                busy_o
`ifdef PICKUP_TX_STATS_EN
   ,
   output logic [31:0]         frame_cnt_o,
   output logic [15:0]         underrun_cnt_o
`endif
);

   localparam int unsigned BCW = (PER_BIT > 1) ? $clog2(PER_BIT) : 1;
   localparam int unsigned TCW = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRAIN = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]                       state_q, state_d;
   logic [BCW-1:0]                   bit_cnt_q, bit_cnt_d;
   logic [TCW-1:0]                   train_cnt_q, train_cnt_d;
   logic [CHANNELS-1:0][PER_BIT-1:0] shift_q, shift_d;
   logic [CHANNELS-1:0]              chan_q, chan_d;
   logic                             bitclk_q, bitclk_d;
   logic                             frameclk_q, frameclk_d;
   logic                             underrun_q, underrun_d;
   logic                             busy_q, busy_d;
   logic                             frame_end_c;
   logic                             last_train_c;
   logic                             active_d;

`ifdef PICKUP_TX_STATS_EN
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] underrun_cnt_q, underrun_cnt_d;
`endif

   assign frame_end_c  = (bit_cnt_q == BCW'(PER_BIT - 1));
   assign last_train_c = (train_cnt_q == TCW'(TRAIN_FRAMES - 1));

   // Upstream handshake: at most one acceptance per frame, on its last bit.
   assign tx_ready_c_o = (state_q == ST_RUN) && enable_i && frame_end_c;

   // Next-state, shift and output computation
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q + BCW'(1);
      train_cnt_d = train_cnt_q;
      underrun_d  = 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         shift_d[c] = {shift_q[c][PER_BIT-2:0], 1'b0};
      end
`ifdef PICKUP_TX_STATS_EN
      frame_cnt_d    = frame_cnt_q;
      underrun_cnt_d = underrun_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d   = '0;
            train_cnt_d = '0;
            shift_d     = '0;
            if (enable_i) begin
               state_d = ST_TRAIN;
               for (int c = 0; c < int'(CHANNELS); c++) begin
                  shift_d[c] = TRAIN_WORD;
               end
`ifdef PICKUP_TX_STATS_EN
               frame_cnt_d    = '0;
               underrun_cnt_d = '0;
`endif
            end
         end

         ST_TRAIN: begin
            if (frame_end_c) begin
               bit_cnt_d   = '0;
               train_cnt_d = train_cnt_q + TCW'(1);
               for (int c = 0; c < int'(CHANNELS); c++) begin
                  shift_d[c] = TRAIN_WORD;
               end
            end
            // Enter RUN for the last training bit so the first word follows with no gap.
            if (last_train_c && (bit_cnt_q == BCW'(PER_BIT - 2))) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (frame_end_c) begin
               bit_cnt_d = '0;
               if (!enable_i) begin
                  state_d = ST_DRAIN;
                  shift_d = '0;
               end else if (tx_valid_i) begin
                  for (int c = 0; c < int'(CHANNELS); c++) begin
                     shift_d[c] = tx_data_i[c*PER_BIT+1 +: PER_BIT];
                  end
`ifdef PICKUP_TX_STATS_EN
                  frame_cnt_d = frame_cnt_q + 32'd1;
`endif
               end else begin
                  shift_d    = '0;
                  underrun_d = 1'b1;
`ifdef PICKUP_TX_STATS_EN
                  if (underrun_cnt_q != 16'hFFFF) begin
                     underrun_cnt_d = underrun_cnt_q + 16'd1;
                  end
`endif
               end
            end
         end

         ST_DRAIN: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
         end

         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
         end
      endcase

      // Line outputs are registered alongside the shift register so they stay phase-aligned.
      active_d   = (state_d == ST_TRAIN) || (state_d == ST_RUN);
      busy_d     = (state_d != ST_IDLE);
      bitclk_d   = active_d && !bit_cnt_d[0];
      frameclk_d = active_d && (bit_cnt_d < BCW'(PER_BIT / 2));
      for (int c = 0; c < int'(CHANNELS); c++) begin
         chan_d[c] = active_d && shift_d[c][PER_BIT-1];
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         train_cnt_q <= '0;
         shift_q     <= '0;
         chan_q      <= '0;
         bitclk_q    <= 1'b0;
         frameclk_q  <= 1'b0;
         underrun_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         train_cnt_q <= train_cnt_d;
         shift_q     <= shift_d;
         chan_q      <= chan_d;
         bitclk_q    <= bitclk_d;
         frameclk_q  <= frameclk_d;
         underrun_q  <= underrun_d;
         busy_q      <= busy_d;
      end
   end

`ifdef PICKUP_TX_STATS_EN
   // Statistics counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_q    <= '0;
         underrun_cnt_q <= '0;
      end else begin
         frame_cnt_q    <= frame_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign frame_cnt_o    = frame_cnt_q;
   assign underrun_cnt_o = underrun_cnt_q;
`endif

   assign channel_data_o = chan_q;
   assign bitclk_o       = bitclk_q;
   assign frameclk_o     = frameclk_q;
   assign underrun_o     = underrun_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_pickup_tx_serializer.sv
// Directed bench for pickup_tx_serializer: reset, training, data frames, underrun, drain and reset abort.
module tb_pickup_tx_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [12:1] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [1:0]  channel_data;
   logic        bitclk;
   logic        frameclk;
   logic        underrun;
   logic        busy;
`ifdef PICKUP_TX_STATS_EN
   logic [31:0] frame_cnt;
   logic [15:0] underrun_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pickup_tx_serializer #(
      .CHANNELS(2), .PER_BIT(6), .MAXBIT(12), .TRAIN_FRAMES(2), .TRAIN_WORD(6'b111000)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .enable_i       (enable),
      .tx_data_i      (tx_data),
      .tx_valid_i     (tx_valid),
      .tx_ready_c_o   (tx_ready),
      .channel_data_o (channel_data),
      .bitclk_o       (bitclk),
      .frameclk_o     (frameclk),
      .underrun_o     (underrun),
      .busy_o         (busy)
`ifdef PICKUP_TX_STATS_EN
      ,
      .frame_cnt_o    (frame_cnt),
      .underrun_cnt_o (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   // {ch1, ch0, bitclk, frameclk, underrun, busy, tx_ready}
   function automatic logic [6:0] outs();
      return {channel_data[1], channel_data[0], bitclk, frameclk, underrun, busy, tx_ready};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
      end
   endtask

   // One full frame of word w; next inputs applied after the last bit is checked.
   task automatic frame(input string tag, input logic [11:0] w, input logic rdy_last,
                        input logic undr, input logic nv, input logic [11:0] nd);
      logic [6:0] e;
      for (int k = 0; k < 6; k++) begin
         step();
         e = {w[11-k], w[5-k], (k % 2) == 0, k < 3, undr && (k == 0), 1'b1, rdy_last && (k == 5)};
         chk(tag, k, 32'(outs()), 32'(e));
         if (k == 5) begin
            tx_valid = nv;
            tx_data  = nd;
         end
      end
   endtask

   initial begin
      logic [11:0] w;
      logic [6:0]  e;

      // T1: reset held, everything quiet
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset", i, 32'(outs()), 32'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("idle", i, 32'(outs()), 32'd0);
      end

      // T2: two training frames of 111000 on both lanes; ready on last training bit
      enable = 1'b1;
      frame("train1", 12'hE38, 1'b0, 1'b0, 1'b0, 12'h000);
      frame("train2", 12'hE38, 1'b1, 1'b0, 1'b1, 12'hA5C);

      // T3/T4: A5C then four more words back-to-back
      frame("a5c",    12'hA5C, 1'b1, 1'b0, 1'b1, 12'h3C9);
      frame("w3c9",   12'h3C9, 1'b1, 1'b0, 1'b1, 12'h0F0);
      frame("w0f0",   12'h0F0, 1'b1, 1'b0, 1'b1, 12'h5A6);
      frame("w5a6",   12'h5A6, 1'b1, 1'b0, 1'b1, 12'h123);
      frame("w123",   12'h123, 1'b1, 1'b0, 1'b0, 12'h000);

      // T5: no valid word at the boundary -> zero frame with underrun pulse
      frame("under",  12'h000, 1'b1, 1'b1, 1'b1, 12'h6B2);
`ifdef PICKUP_TX_STATS_EN
      chk("underrun_cnt", 0, 32'(underrun_cnt), 32'd1);
      chk("frame_cnt", 0, frame_cnt, 32'd5);
`endif

      // T6a: enable drops at bit 2; frame completes, then DRAIN and IDLE
      w = 12'h6B2;
      for (int k = 0; k < 6; k++) begin
         step();
         e = {w[11-k], w[5-k], (k % 2) == 0, k < 3, 1'b0, 1'b1, 1'b0};
         chk("drop", k, 32'(outs()), 32'(e));
         if (k == 2) enable = 1'b0;
      end
      step();
      chk("drain", 0, 32'(outs()), 32'b0000010);
      enable   = 1'b1;
      tx_valid = 1'b0;
      step();
      chk("idle_after", 0, 32'(outs()), 32'd0);

      // T6b: retrain, then async reset mid-frame
      for (int k = 0; k < 3; k++) begin
         step();
         e = {1'b1, 1'b1, (k % 2) == 0, 1'b1, 1'b0, 1'b1, 1'b0};
         chk("retrain", k, 32'(outs()), 32'(e));
`ifdef PICKUP_TX_STATS_EN
         if (k == 0) begin
            chk("frame_cnt_clr", 0, frame_cnt, 32'd0);
            chk("underrun_cnt_clr", 0, 32'(underrun_cnt), 32'd0);
         end
`endif
      end
      rst_n = 1'b0;
      #1;
      chk("rst_async", 0, 32'(outs()), 32'd0);
      step();
      chk("rst_hold", 0, 32'(outs()), 32'd0);
      rst_n  = 1'b1;
      enable = 1'b0;
      step();
      chk("rst_idle", 0, 32'(outs()), 32'd0);
      step();
      chk("rst_idle", 1, 32'(outs()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
